// File: rtl/mdio_mgmt_arbiter.sv
// Shared Clause-22 MDIO management master: round-robin arbitration among NUM_REQ
// clients, MDC generation and full-frame serialisation with read-data capture.
module mdio_mgmt_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [5*NUM_REQ-1:0]    req_phyad,
    input  logic [5*NUM_REQ-1:0]    req_regad,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_rdata,
    output logic                    busy,
    output logic                    mdc,
    input  logic                    mdio_i,
    output logic                    mdio_o,
    output logic                    mdio_t
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, RESP} state_t;

    state_t          state;
    logic [RR_W-1:0] rr;
    logic [RR_W-1:0] gnt;
    logic            wr;
    logic [31:0]     tx;
    logic [14:0]     rx;
    logic [PH_W-1:0] ph;
    logic [5:0]      pre_cnt;
    logic [5:0]      bit_cnt;

    logic            any_req;
    logic            found;
    logic [RR_W-1:0] pick;
    logic [RR_W-1:0] rr_next;

    function automatic logic [31:0] build_frame(input logic w, input logic [4:0] pa,
                                                input logic [4:0] ra, input logic [15:0] d);
        build_frame = {2'b01, w ? 2'b01 : 2'b10, pa, ra, w ? 2'b10 : 2'b00, w ? d : 16'h0000};
    endfunction

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        any_req = |req_valid;
        found   = 1'b0;
        pick    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = RR_W'((int'(rr) + k) % NUM_REQ);
            end
        end
        rr_next = (pick == RR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr        <= '0;
            gnt       <= '0;
            wr        <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            ph        <= '0;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    mdc    <= 1'b0;
                    mdio_o <= 1'b0;
                    mdio_t <= 1'b1;
                    if (any_req) begin
                        gnt       <= pick;
                        wr        <= req_write[pick];
                        tx        <= build_frame(req_write[pick],
                                                 req_phyad[int'(pick)*5 +: 5],
                                                 req_regad[int'(pick)*5 +: 5],
                                                 req_wdata[int'(pick)*16 +: 16]);
                        rr        <= rr_next;
                        req_ready <= NUM_REQ'(1) << pick;
                        busy      <= 1'b1;
                        // Phase parked at the end so the first bit starts on the next edge.
                        ph        <= PH_LAST;
                        pre_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= (PREAMBLE_LEN == 0) ? FRAME : PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (ph == PH_LAST) begin
                        ph     <= '0;
                        mdc    <= 1'b0;
                        mdio_t <= 1'b0;
                        if (pre_cnt == 6'(PREAMBLE_LEN)) begin
                            state   <= FRAME;
                            mdio_o  <= tx[31];
                            tx      <= {tx[30:0], 1'b0};
                            bit_cnt <= 6'd1;
                        end else begin
                            mdio_o  <= 1'b1;
                            pre_cnt <= pre_cnt + 6'd1;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                        if (ph == PH_RISE) mdc <= 1'b1;
                    end
                end

                FRAME: begin
                    if (ph == PH_LAST) begin
                        ph  <= '0;
                        mdc <= 1'b0;
                        // The bit just ending is a read-data bit when bit_cnt-1 >= 16.
                        if (!wr && bit_cnt >= 6'd17) rx <= {rx[13:0], mdio_i};
                        if (bit_cnt == 6'd32) begin
                            state     <= RESP;
                            mdio_o    <= 1'b0;
                            mdio_t    <= 1'b1;
                            rsp_valid <= NUM_REQ'(1) << gnt;
                            rsp_rdata <= wr ? 16'h0000 : {rx, mdio_i};
                        end else begin
                            mdio_o  <= tx[31];
                            tx      <= {tx[30:0], 1'b0};
                            mdio_t  <= !wr && (bit_cnt >= 6'd14);
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                        if (ph == PH_RISE) mdc <= 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdio_mgmt_arbiter.md
Name: mdio_mgmt_arbiter

Overview:
- Shared MDIO management master for the Ethernet IP.
- Round-robin arbitrates among NUM_REQ clients (link-init sequencer, status poller, debug host) requesting Clause-22 register reads and writes.
- Generates MDC and serialises complete frames (preamble, ST, OP, PHYAD, REGAD, TA, DATA) onto the tri-stated MDIO pad signals.
- Returns read data to the granted client.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
CLK_DIV, 4, clk cycles per MDC half-period (>=2)
PREAMBLE_LEN, 32, preamble '1' bits before ST (0..32; 0 = preamble suppression)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-client transaction request
req_write  input  NUM_REQ  1 = write, 0 = read
req_phyad  input  5*NUM_REQ  PHY address, client i at [5i+4:5i]
req_regad  input  5*NUM_REQ  register address, same packing
req_wdata  input  16*NUM_REQ  write data, client i at [16i+15:16i]
req_ready  output  NUM_REQ  one-cycle accept pulse to grantee
rsp_valid  output  NUM_REQ  one-cycle completion pulse to grantee
rsp_rdata  output  16  read data (0 for writes), valid with rsp_valid
busy  output  1  high from grant until end of RESP
mdc  output  1  management clock to PHY
mdio_i  input  1  MDIO pad input
mdio_o  output  1  MDIO pad output value
mdio_t  output  1  MDIO tri-state (1 = released/input)

Behaviour:
- Reset (async, immediate) values:
  - state IDLE, rr pointer 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - mdc=0, mdio_o=0, mdio_t=1.
  - A frame in progress is abandoned and no rsp_valid is issued.
- FSM states: IDLE, PREAMBLE, FRAME, RESP.
- IDLE:
  - mdc=0, mdio_t=1, mdio_o=0.
  - On an edge with any req_valid set, grant g = first set bit searching from rr pointer upward with wrap.
  - On that same edge: latch write, phyad, regad, wdata of g; req_ready[g]<=1 for exactly one cycle; busy<=1; rr<=(g+1) mod NUM_REQ.
  - Next state is PREAMBLE, or FRAME if PREAMBLE_LEN=0.
- Bit timing:
  - Each bit lasts 2*CLK_DIV clk cycles: CLK_DIV cycles with mdc=0, then CLK_DIV cycles with mdc=1.
  - mdio_o and mdio_t change only on the edge where mdc goes 0 (bit start).
  - mdio_i is sampled on the edge where mdc falls 1->0 (bit end).
- PREAMBLE: PREAMBLE_LEN bits with mdio_t=0, mdio_o=1.
- FRAME: 32 bits, MSB-first per field.
  - ST=01.
  - OP=01 for write, 10 for read.
  - PHYAD[4:0], then REGAD[4:0].
  - Write: TA=10, then DATA[15:0], all with mdio_t=0.
  - Read: mdio_t=1 during both TA bits and all 16 data bits (mdio_o=0). DATA[15:0] is shifted in MSB-first from the samples.
- RESP (one clk cycle):
  - rsp_valid[g]=1.
  - rsp_rdata = captured data for a read, 0 for a write.
  - mdc=0, mdio_t=1.
  - busy drops at the transition to IDLE.
  - rsp_rdata holds its value until the next RESP.
- Latency, grant edge to rsp_valid = (PREAMBLE_LEN+32)*2*CLK_DIV + 1 cycles (default 513).
- req_valid asserted while not IDLE is ignored until return to IDLE. No queueing.
- Back-to-back: a client still asserting req_valid in IDLE is re-arbitrated against the updated rr pointer. The minimum gap between frames is 1 IDLE cycle.
- A client deasserting req_valid before grant is never served. Fields are sampled only on the grant edge.
- Unused mdc/mdio_t values in IDLE are stable, with no glitches.

Test Plan:
- Single write, client0, phy=0x01, reg=0x00, wdata=0x1140, defaults:
  - req_ready[0] pulses 1 cycle after valid.
  - 32 ones, then 01 01 00001 00000 10 0001000101000000 on mdio_o with mdio_t=0.
  - rsp_valid[0] 513 cycles after grant, rsp_rdata=0.
- Single read, client1, phy=0x03, reg=0x01; PHY model drives 0x796D after TA:
  - mdio_t=1 from TA bit 1 through the last data bit.
  - rsp_valid[1] with rsp_rdata=0x796D; mdio_t returns 1.
- Contention, both clients valid continuously for 4 transactions:
  - Grants alternate 0,1,0,1.
  - Exactly one req_ready and one rsp_valid per frame.
  - busy low for exactly 1 cycle between frames.
- PREAMBLE_LEN=0, CLK_DIV=2, write:
  - ST bits start on the first bit after grant.
  - mdc period 4 clk cycles.
  - rsp_valid at grant+129.
- Reset asserted mid-DATA of a read:
  - mdc=0, mdio_t=1, busy=0 immediately.
  - No rsp_valid.
  - After release, a new request is served from client0 (rr=0).
- req_valid pulsed by client1 for one cycle while a client0 frame is active:
  - Client1 is never granted.
  - mdio_t never 0 after client0's RESP.
